mcpu_run_ctrl: RTL and testbench
================================

Name: mcpu_run_ctrl

Overview:
- Run/load sequencer between the host, the 8-bit MCPU core and its 64x8 async-read program/data SRAM.
- Holds the CPU in reset, streams a program into SRAM and releases the CPU.
- Stops the CPU on a write to the halt address or on watchdog expiry, then reports the result.
- Owns the SRAM port in all states; passes CPU bus signals through only in RUN.

Parameters:
ADR_W, 6, SRAM/CPU address width; depth is 2**ADR_W.
HALT_ADR, 63, CPU write to this address ends the run.
WDOG_W, 16, watchdog counter width; timeout when the counter reaches all-ones.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  pulse: begin a load; ignored unless IDLE/DONE
in_data  in  8  program byte
in_valid  in  1  program byte valid
in_last  in  1  marks final program byte
in_ready  out  1  high only in LOAD
cpu_rst_n  out  1  registered reset to CPU (low = held)
cpu_adr  in  ADR_W  CPU address
cpu_wdata  in  8  CPU write data (split from CPU data bus at top level)
cpu_oe_n  in  1  CPU read strobe (clk-qualified, active-low)
cpu_we_n  in  1  CPU write strobe (clk-qualified, active-low)
mem_adr  out  ADR_W  SRAM address
mem_wdata  out  8  SRAM write data
mem_rdata  in  8  SRAM read data
mem_oe_n  out  1  SRAM output enable, active-low
mem_we_n  out  1  SRAM write enable, active-low
result  out  8  byte captured at halt
busy  out  1  state is LOAD, RUN or DUMP
done  out  1  run finished (sticky until next start)
timeout  out  1  run ended by watchdog

Behaviour:
- States: IDLE, LOAD, RUN, DONE, DUMP (DUMP only with the optional feature).
- Reset (rst=0 at posedge, from any state, including mid-operation):
  - State IDLE; cpu_rst_n=0; in_ready=0; result=0; done=0; timeout=0; pointer=0; watchdog=0; write-pending=0.
  - mem_oe_n=1 and mem_we_n=1 while rst=0.
- SRAM strobes follow CPU bus timing:
  - mem_we_n = clk | ~wr_en; mem_oe_n = clk | ~rd_en.
  - Accesses occur in the clk-low half; read data is sampled at the closing posedge.
- IDLE/DONE: start=1 -> LOAD; pointer=0; result, done and timeout cleared.
- LOAD:
  - in_ready=1. An accepted byte (in_valid & in_ready at posedge) latches in_data and pointer into a write buffer and sets write-pending.
  - The write occurs in the next cycle's low phase (1-cycle latency). Back-to-back accepts run at 1 byte/cycle. Then pointer++.
  - Last byte is accepted when in_last=1 or pointer==2**ADR_W-1. Then in_ready=0 from the next cycle.
  - At the posedge that retires the final write: state->RUN, cpu_rst_n<=1, watchdog=0.
- RUN:
  - mem_adr, mem_wdata, mem_oe_n and mem_we_n are driven combinationally from the cpu_* inputs.
  - Watchdog increments every posedge.
  - Halt snoop: a negedge flop samples hit=(~cpu_we_n & cpu_adr==HALT_ADR) plus cpu_wdata. That write still reaches the SRAM.
  - Next posedge with hit=1: result<=sampled data; done<=1; cpu_rst_n<=0; state->DONE.
  - Watchdog reaches all-ones: timeout<=1; done<=1; cpu_rst_n<=0; state->DONE.
  - Halt hit and watchdog expiry at the same posedge: halt wins, timeout=0.
- start while busy: ignored. in_valid outside LOAD: ignored.
- cpu_rst_n is low in every state except RUN.
- busy=1 in LOAD/RUN/DUMP.

Optional Feature:
MCPU_RUN_CTRL_DUMP_EN
- Defined: adds ports dump_req (in, 1), out_data (out, 8), out_valid (out, 1), out_ready (in, 1).
- dump_req in DONE or IDLE -> DUMP, pointer=0.
- DUMP: mem_adr=pointer; rd_en = ~out_valid | out_ready. On a posedge with rd_en: out_data<=mem_rdata, out_valid<=1, pointer++.
- out_data/out_valid hold stable while out_ready=0.
- After the byte at address 2**ADR_W-1 is consumed: out_valid=0 and state->DONE; done/result/timeout are unchanged.
- start has priority over dump_req.
- Reset clears out_valid and out_data.
- Not defined: no dump ports, no DUMP state; dump_req logic is absent.

Test Plan:
- Load {0x80,0x3F,0x2A} with in_last on byte 3 -> SRAM[0..2] written. in_ready=0 one cycle after the last accept. cpu_rst_n=1 exactly one posedge after the last accept.
- Program storing 0x2A to address 63 -> done=1, result=0x2A, timeout=0, cpu_rst_n=0 at the posedge after the write's low phase. SRAM[63]=0x2A.
- WDOG_W=4, self-jump program -> after 15 RUN posedges: timeout=1, done=1, result=0x00, cpu_rst_n=0.
- 64 bytes streamed with in_last=0 and in_valid gaps -> all 64 written in order; auto entry to RUN after byte 63.
- DUMP_EN, SRAM[i]=i^0x55, out_ready toggling 1010... -> 64 bytes 0x55,0x54,... in order, no drop or duplicate; DONE afterwards.
- rst=0 for 1 cycle after 2 bytes of LOAD -> IDLE, in_ready=0, cpu_rst_n=0, done=0. A following start restarts at address 0.

Source files
------------

// File: rtl/mcpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_run_ctrl
//
// Run/load sequencer sitting between a host, the 8-bit MCPU core and the
// core's asynchronous-read program/data SRAM (2**ADR_W x 8).
//
// Operation:
//   IDLE/DONE --start--> LOAD : host streams program bytes into SRAM from 0
//   LOAD --final write--> RUN : CPU released from reset, watchdog cleared
//   RUN --halt write / watchdog expiry--> DONE : CPU held in reset again
//   With MCPU_RUN_CTRL_DUMP_EN defined, IDLE/DONE --dump_req--> DUMP streams
//   the whole SRAM back out and returns to DONE.
//
// Handshake rule (in_* and out_* streams): a byte moves on a rising clk edge
// where valid and ready are both high. The producer holds data/valid stable
// until that edge; ready may change freely and never depends on valid.
//
// SRAM strobes are clk-qualified: an enable only takes effect in the low
// half of the clock, and read data is sampled at the closing rising edge.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   start                    begin a load (honoured in IDLE/DONE only)
//   in_data/valid/last/ready program byte stream from the host
//   cpu_rst_n                registered reset to the CPU (low = held)
//   cpu_adr/wdata/oe_n/we_n  CPU bus, forwarded to the SRAM only in RUN
//   mem_adr/wdata/oe_n/we_n  SRAM port, owned by this block in every state
//   mem_rdata                SRAM read data
//   result                   byte written to HALT_ADR when the run stopped
//   busy/done/timeout        status (done sticky until the next start)
//   dump_req, out_data/valid/ready  SRAM read-back stream (DUMP_EN only)
//   dbg_state                current FSM state encoding
//
// Optional feature macro: MCPU_RUN_CTRL_DUMP_EN
// ---------------------------------------------------------------------------
module mcpu_run_ctrl #(
    parameter int ADR_W    = 6,
    parameter int HALT_ADR = 63,
    parameter int WDOG_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             cpu_rst_n,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [7:0]       cpu_wdata,
    input  logic             cpu_oe_n,
    input  logic             cpu_we_n,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic             mem_oe_n,
    output logic             mem_we_n,
    output logic [7:0]       result,
    output logic             busy,
    output logic             done,
    output logic             timeout,
`ifdef MCPU_RUN_CTRL_DUMP_EN
    input  logic             dump_req,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
`endif
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3
`ifdef MCPU_RUN_CTRL_DUMP_EN
        ,
        S_DUMP = 3'd4
`endif
    } state_t;

    localparam logic [ADR_W-1:0]  ADR_MAX   = {ADR_W{1'b1}};
    localparam logic [ADR_W-1:0]  HALT_A    = ADR_W'(HALT_ADR);
    // Expiry is flagged on the edge that moves the counter onto all-ones.
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADR_W-1:0]  r_ptr;
    logic [ADR_W-1:0]  r_wbuf_adr;
    logic [7:0]        r_wbuf_data;
    logic              r_wpend;
    logic              r_last_acc;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_cpu_rst_n;
    logic [7:0]        r_result;
    logic              r_done;
    logic              r_timeout;
    logic              r_hit;
    logic [7:0]        r_hit_data;

    logic              w_accept;
    logic              w_acc_last;
    logic              w_wdog_exp;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_in_ready;

`ifdef MCPU_RUN_CTRL_DUMP_EN
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_dump_end;
    logic              w_dump_rd;

    // A new byte is fetched whenever the output slot is empty or being
    // drained this cycle, until the top address has been fetched.
    assign w_dump_rd = (r_state == S_DUMP) && !r_dump_end &&
                       (!r_out_valid || out_ready);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
`endif

    assign w_in_ready = (r_state == S_LOAD) && !r_last_acc;
    assign w_accept   = in_valid && w_in_ready;
    assign w_acc_last = w_accept && (in_last || (r_ptr == ADR_MAX));
    assign w_wdog_exp = (r_wdog == WDOG_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_LOAD;
`ifdef MCPU_RUN_CTRL_DUMP_EN
                else if (dump_req) w_state_nxt = S_DUMP;
`endif
            end
            S_LOAD: if (r_wpend && r_last_acc) w_state_nxt = S_RUN;
            S_RUN:  if (r_hit || w_wdog_exp) w_state_nxt = S_DONE;
`ifdef MCPU_RUN_CTRL_DUMP_EN
            S_DUMP: if (r_dump_end && out_ready) w_state_nxt = S_DONE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                mem_adr   = r_wbuf_adr;
                mem_wdata = r_wbuf_data;
                w_wr_en   = r_wpend;
                busy      = 1'b1;
            end
            S_RUN: begin
                mem_adr   = cpu_adr;
                mem_wdata = cpu_wdata;
                w_wr_en   = !cpu_we_n;
                w_rd_en   = !cpu_oe_n;
                busy      = 1'b1;
            end
`ifdef MCPU_RUN_CTRL_DUMP_EN
            S_DUMP: begin
                mem_adr = r_ptr;
                w_rd_en = w_dump_rd;
                busy    = 1'b1;
            end
`endif
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Strobes are only asserted in the clk-low half and never during reset.
    assign mem_we_n  = clk | !(w_wr_en && rst);
    assign mem_oe_n  = clk | !(w_rd_en && rst);
    assign in_ready  = w_in_ready;
    assign cpu_rst_n = r_cpu_rst_n;
    assign result    = r_result;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

    // Halt snoop: the CPU write strobe is valid around the falling edge, so
    // the hit and its data are captured there and acted on at the next
    // rising edge. The write itself still reaches the SRAM.
    always_ff @(negedge clk) begin
        if (!rst) begin
            r_hit      <= 1'b0;
            r_hit_data <= '0;
        end else begin
            r_hit      <= (r_state == S_RUN) && !cpu_we_n && (cpu_adr == HALT_A);
            r_hit_data <= cpu_wdata;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_wbuf_adr  <= '0;
            r_wbuf_data <= '0;
            r_wpend     <= 1'b0;
            r_last_acc  <= 1'b0;
            r_wdog      <= '0;
            r_cpu_rst_n <= 1'b0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef MCPU_RUN_CTRL_DUMP_EN
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_dump_end  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_ptr      <= '0;
                        r_result   <= '0;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_wpend    <= 1'b0;
                        r_last_acc <= 1'b0;
                    end
`ifdef MCPU_RUN_CTRL_DUMP_EN
                    else if (dump_req) begin
                        r_ptr       <= '0;
                        r_out_valid <= 1'b0;
                        r_dump_end  <= 1'b0;
                    end
`endif
                end
                S_LOAD: begin
                    // The accepted byte is written during the next low phase.
                    r_wpend <= w_accept;
                    if (w_accept) begin
                        r_wbuf_adr  <= r_ptr;
                        r_wbuf_data <= in_data;
                        r_ptr       <= r_ptr + 1'b1;
                    end
                    if (w_acc_last) r_last_acc <= 1'b1;
                    if (r_wpend && r_last_acc) begin
                        r_cpu_rst_n <= 1'b1;
                        r_wdog      <= '0;
                    end
                end
                S_RUN: begin
                    r_wdog <= r_wdog + 1'b1;
                    // A halt write beats a simultaneous watchdog expiry.
                    if (r_hit) begin
                        r_result    <= r_hit_data;
                        r_done      <= 1'b1;
                        r_cpu_rst_n <= 1'b0;
                    end else if (w_wdog_exp) begin
                        r_timeout   <= 1'b1;
                        r_done      <= 1'b1;
                        r_cpu_rst_n <= 1'b0;
                    end
                end
`ifdef MCPU_RUN_CTRL_DUMP_EN
                S_DUMP: begin
                    if (r_dump_end) begin
                        if (out_ready) r_out_valid <= 1'b0;
                    end else if (w_dump_rd) begin
                        r_out_data  <= mem_rdata;
                        r_out_valid <= 1'b1;
                        r_ptr       <= r_ptr + 1'b1;
                        if (r_ptr == ADR_MAX) r_dump_end <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_cpu_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_run_ctrl.sv
module tb_mcpu_run_ctrl;

  localparam int ADR_W = 6;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, in_valid, in_last, in_ready, cpu_rst_n;
  logic [7:0]       in_data, cpu_wdata, mem_wdata, mem_rdata, result;
  logic [ADR_W-1:0] cpu_adr, mem_adr;
  logic             cpu_oe_n, cpu_we_n, mem_oe_n, mem_we_n;
  logic             busy, done, timeout;
  logic [2:0]       dbg_state;
`ifdef MCPU_RUN_CTRL_DUMP_EN
  logic             dump_req, out_valid, out_ready;
  logic [7:0]       out_data;
`endif

  mcpu_run_ctrl #(.ADR_W(ADR_W), .HALT_ADR(63), .WDOG_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cpu_rst_n(cpu_rst_n), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .result(result), .busy(busy), .done(done), .timeout(timeout),
`ifdef MCPU_RUN_CTRL_DUMP_EN
    .dump_req(dump_req), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- SRAM model (async read) ----------------
  logic [7:0] sram [64];
  assign mem_rdata = sram[mem_adr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [13:0] wr_exp_q[$];   // {adr, data} of every expected SRAM write
  logic [8:0]  res_exp_q[$];  // {timeout, result} of every expected run end
  logic [7:0]  dump_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Write monitor: an SRAM write shows up as mem_we_n low in the low phase.
  always @(negedge clk) begin
    #2;
    if (mem_we_n === 1'b0) begin
      sram[mem_adr] = mem_wdata;
      if (wr_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sram_wr_extra: got write 0x%0h to 0x%0h, expected none", mem_wdata, mem_adr);
      end else begin
        chk("sram_wr", {mem_adr, mem_wdata}, wr_exp_q.pop_front());
      end
    end
  end

  // Result monitor: fires when done rises.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    #1;
    if (done === 1'b1 && prev_done === 1'b0) begin
      if (res_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL run_end_extra: got result 0x%0h timeout %0b, expected none", result, timeout);
      end else begin
        chk("run_result", {timeout, result}, res_exp_q.pop_front());
        chk("run_end_cpu_rst_n", cpu_rst_n, 0);
      end
    end
    prev_done = done;
  end

`ifdef MCPU_RUN_CTRL_DUMP_EN
  always @(negedge clk) begin
    #1;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (dump_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL dump_extra: got byte 0x%0h, expected none", out_data);
      end else begin
        chk("dump_byte", out_data, dump_exp_q.pop_front());
      end
    end
  end
`endif

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Present one byte for one cycle; caller drops in_valid afterwards.
  task automatic send(input logic [7:0] d, input logic last, input logic [5:0] adr);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    wr_exp_q.push_back({adr, d});
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Global bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 8'h00;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    cpu_adr = '0; cpu_wdata = 8'h00; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
`ifdef MCPU_RUN_CTRL_DUMP_EN
    dump_req = 1'b0; out_ready = 1'b0;
`endif
    repeat (3) tick();
    at_neg();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done_timeout_result", {done, timeout, result}, 0);
    chk("rst_strobes", {mem_we_n, mem_oe_n}, 2'b11);
    tick();
    rst = 1'b1;
    tick();

    // ---- load {80,3F,2A}, last on byte 3 ----
    do_start();
    chk("load_in_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    send(8'h80, 1'b0, 6'd0);
    send(8'h3F, 1'b0, 6'd1);
    send(8'h2A, 1'b1, 6'd2);
    in_valid = 1'b0; in_last = 1'b0;
    chk("last_in_ready_low", in_ready, 0);
    chk("last_cpu_rst_n_held", cpu_rst_n, 0);
    tick();
    chk("load_to_run_cpu_rst_n", cpu_rst_n, 1);
    chk("load_to_run_state", dbg_state, ST_RUN);

    // ---- run: one read, then store 0x2A to the halt address ----
    cpu_oe_n = 1'b0; cpu_adr = 6'd0;
    at_neg();
    chk("run_read_strobe", mem_oe_n, 0);
    chk("run_read_data", mem_rdata, 8'h80);
    tick();
    cpu_oe_n = 1'b1; cpu_we_n = 1'b0; cpu_adr = 6'd63; cpu_wdata = 8'h2A;
    wr_exp_q.push_back({6'd63, 8'h2A});
    res_exp_q.push_back({1'b0, 8'h2A});
    tick();
    cpu_we_n = 1'b1;
    chk("halt_done", done, 1);
    chk("halt_state", dbg_state, ST_DONE);
    chk("halt_sram63", sram[63], 8'h2A);
    // CPU bus must not reach the SRAM outside RUN
    cpu_we_n = 1'b0; cpu_adr = 6'd5;
    at_neg();
    chk("done_we_blocked", mem_we_n, 1);
    tick();
    cpu_we_n = 1'b1;

    // ---- watchdog: self-jump program, 15 RUN edges ----
    do_start();
    chk("restart_clears_done", {done, result}, 0);
    send(8'h00, 1'b1, 6'd0);
    in_valid = 1'b0; in_last = 1'b0;
    res_exp_q.push_back({1'b1, 8'h00});
    tick();
    chk("wdog_run_entry", cpu_rst_n, 1);
    cpu_oe_n = 1'b0; cpu_adr = 6'd0;
    repeat (14) tick();
    chk("wdog_not_yet", {done, dbg_state}, {1'b0, ST_RUN});
    tick();
    chk("wdog_timeout", {timeout, done, result, cpu_rst_n}, {1'b1, 1'b1, 8'h00, 1'b0});
    cpu_oe_n = 1'b1;

    // ---- 64 bytes, no in_last, gaps, stray start mid-stream ----
    do_start();
    for (int i = 0; i < 64; i++) begin
      if (i % 3 == 2) begin
        in_valid = 1'b0;
        tick();
      end
      start = (i == 20);
      send(8'((i * 37 + 11) & 8'hFF), 1'b0, 6'(i));
    end
    in_valid = 1'b0; start = 1'b0;
    chk("full_in_ready_low", in_ready, 0);
    tick();
    chk("full_auto_run", {cpu_rst_n, dbg_state}, {1'b1, ST_RUN});
    res_exp_q.push_back({1'b1, 8'h00});
    for (int k = 0; k < 40 && done !== 1'b1; k++) tick();
    chk("full_run_ends", done, 1);
    tick();

`ifdef MCPU_RUN_CTRL_DUMP_EN
    // ---- dump with out_ready toggling ----
    for (int i = 0; i < 64; i++) begin
      sram[i] = 8'(i) ^ 8'h55;
      dump_exp_q.push_back(8'(i) ^ 8'h55);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int c = 0; c < 400 && dbg_state !== ST_DONE; c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end
    out_ready = 1'b0;
    chk("dump_back_to_done", dbg_state, ST_DONE);
    chk("dump_keeps_status", {done, timeout, out_valid}, 3'b110);
    chk("dump_all_bytes", dump_exp_q.size(), 0);
`endif

    // ---- reset in the middle of a load ----
    do_start();
    send(8'hA0, 1'b0, 6'd0);
    send(8'hA1, 1'b0, 6'd1);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_state", dbg_state, ST_IDLE);
    chk("midrst_outs", {in_ready, cpu_rst_n, done, timeout}, 4'b0000);
    do_start();
    send(8'hC3, 1'b1, 6'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("midrst_run", cpu_rst_n, 1);
    cpu_we_n = 1'b0; cpu_adr = 6'd63; cpu_wdata = 8'h11;
    wr_exp_q.push_back({6'd63, 8'h11});
    res_exp_q.push_back({1'b0, 8'h11});
    tick();
    cpu_we_n = 1'b1;
    chk("midrst_halt_result", {done, result}, {1'b1, 8'h11});
    repeat (2) tick();

    // ---- report ----
    chk("wr_queue_drained", wr_exp_q.size(), 0);
    chk("res_queue_drained", res_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
